// File: rtl/controller_pkg.sv
// Shared types and constants for the I3C target-reset controller.
// Contents:
//   target_reset_action_e     - action armed by RSTACT (none / periph / chip)
//   target_reset_ctrl_state_e - controller FSM states
//   RstActDef*                - RSTACT defining-byte encodings
package controller_pkg;

  typedef enum logic [1:0] {
    RstActNone   = 2'h0,
    RstActPeriph = 2'h1,
    RstActChip   = 2'h2
  } target_reset_action_e;

  typedef enum logic [1:0] {
    TrcIdle,
    TrcPeriphReq,
    TrcChipRst,
    TrcHoldoff
  } target_reset_ctrl_state_e;

  localparam logic [7:0] RstActDefNone   = 8'h00;
  localparam logic [7:0] RstActDefPeriph = 8'h01;
  localparam logic [7:0] RstActDefChip   = 8'h02;

endpackage

// File: rtl/target_reset_controller.sv
// Sequences the response to an I3C Target Reset Pattern: takes the detector's
// one-cycle pulse, applies the action armed by RSTACT, and drives the SoC
// reset requests. A second pattern with no GETSTATUS/RSTACT in between
// escalates to a whole-chip reset.
// Ports:
//   clk_i, rst_ni            - clock, asynchronous active-low reset
//   enable_i                 - block enable; 0 forces Idle and ignores detects
//   target_reset_detect_i    - reset-pattern detect pulse
//   rstact_valid_i/defbyte_i - RSTACT defining byte strobe and value
//   getstatus_i              - GETSTATUS completed pulse
//   periph_reset_req_o/ack_i - peripheral reset handshake
//   chip_reset_o             - whole-chip reset request (level)
//   action_o                 - armed action (0 none, 1 periph, 2 chip)
//   escalate_o               - escalation armed
//   rstact_err_o             - pulse on reserved defining byte
//   timeout_o                - pulse on peripheral ack timeout
module target_reset_controller
  import controller_pkg::*;
#(
  parameter logic [15:0] PeriphAckTimeout = 16'd1000,
  parameter logic [15:0] ChipResetCycles  = 16'd64,
  parameter logic [15:0] HoldoffCycles    = 16'd256
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       enable_i,
  input  logic       target_reset_detect_i,
  input  logic       rstact_valid_i,
  input  logic [7:0] rstact_defbyte_i,
  input  logic       getstatus_i,
  output logic       periph_reset_req_o,
  input  logic       periph_reset_ack_i,
  output logic       chip_reset_o,
  output logic [1:0] action_o,
  output logic       escalate_o,
  output logic       rstact_err_o,
  output logic       timeout_o
);

  target_reset_ctrl_state_e state_q, state_d;
  target_reset_action_e     action_q, action_d;
  logic [15:0]              cnt_q, cnt_d;
  logic                     escalate_q, escalate_d;
  logic                     rstact_err_q, rstact_err_d;
  logic                     timeout_q, timeout_d;
  logic                     detect_accept;

  assign detect_accept = enable_i && target_reset_detect_i && (state_q == TrcIdle);

  always_comb begin
    state_d   = state_q;
    timeout_d = 1'b0;
    unique case (state_q)
      TrcIdle: begin
        if (detect_accept) begin
          // Decision uses the pre-update action/escalate values.
          if (escalate_q || (action_q == RstActChip)) state_d = TrcChipRst;
          else if (action_q == RstActPeriph)          state_d = TrcPeriphReq;
          else                                        state_d = TrcHoldoff;
        end
      end
      TrcPeriphReq: begin
        if (!enable_i) begin
          state_d = TrcIdle;
        end else if (periph_reset_ack_i) begin
          state_d = TrcHoldoff;
        end else if (cnt_q == PeriphAckTimeout - 16'd1) begin
          timeout_d = 1'b1;
          state_d   = TrcChipRst;
        end
      end
      // Chip reset runs to completion regardless of enable_i.
      TrcChipRst: begin
        if (cnt_q == ChipResetCycles - 16'd1) state_d = TrcHoldoff;
      end
      TrcHoldoff: begin
        if (!enable_i || (cnt_q == HoldoffCycles - 16'd1)) state_d = TrcIdle;
      end
      default: state_d = TrcIdle;
    endcase
  end

  // Counter restarts on every state change and saturates; idle keeps it at 0.
  always_comb begin
    if ((state_d != state_q) || (state_q == TrcIdle)) cnt_d = '0;
    else if (cnt_q != '1)                             cnt_d = cnt_q + 16'd1;
    else                                              cnt_d = cnt_q;
  end

  // Accepted detect overrides any same-cycle RSTACT/GETSTATUS update.
  always_comb begin
    action_d     = action_q;
    escalate_d   = escalate_q;
    rstact_err_d = 1'b0;
    if (rstact_valid_i) begin
      escalate_d = 1'b0;
      unique case (rstact_defbyte_i)
        RstActDefNone:   action_d = RstActNone;
        RstActDefPeriph: action_d = RstActPeriph;
        RstActDefChip:   action_d = RstActChip;
        default:         rstact_err_d = 1'b1;
      endcase
    end
    if (getstatus_i) escalate_d = 1'b0;
    if (detect_accept) begin
      escalate_d = 1'b1;
      action_d   = RstActPeriph;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= TrcIdle;
      action_q     <= RstActPeriph;
      cnt_q        <= '0;
      escalate_q   <= 1'b0;
      rstact_err_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      action_q     <= action_d;
      cnt_q        <= cnt_d;
      escalate_q   <= escalate_d;
      rstact_err_q <= rstact_err_d;
      timeout_q    <= timeout_d;
    end
  end

  assign periph_reset_req_o = (state_q == TrcPeriphReq);
  assign chip_reset_o       = (state_q == TrcChipRst);
  assign action_o           = action_q;
  assign escalate_o         = escalate_q;
  assign rstact_err_o       = rstact_err_q;
  assign timeout_o          = timeout_q;

endmodule

// File: tb/tb_target_reset_controller.sv
// Directed bench for target_reset_controller: a vector table for single-cycle
// decode/transition behaviour, then hand-written multi-cycle sequences.
module tb_target_reset_controller;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       enable_i;
  logic       detect_i;
  logic       rstact_valid_i;
  logic [7:0] rstact_defbyte_i;
  logic       getstatus_i;
  logic       periph_reset_req_o;
  logic       periph_reset_ack_i;
  logic       chip_reset_o;
  logic [1:0] action_o;
  logic       escalate_o;
  logic       rstact_err_o;
  logic       timeout_o;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  target_reset_controller #(
    .PeriphAckTimeout(16'd1000),
    .ChipResetCycles (16'd64),
    .HoldoffCycles   (16'd256)
  ) dut (
    .clk_i                (clk),
    .rst_ni               (rst_ni),
    .enable_i             (enable_i),
    .target_reset_detect_i(detect_i),
    .rstact_valid_i       (rstact_valid_i),
    .rstact_defbyte_i     (rstact_defbyte_i),
    .getstatus_i          (getstatus_i),
    .periph_reset_req_o   (periph_reset_req_o),
    .periph_reset_ack_i   (periph_reset_ack_i),
    .chip_reset_o         (chip_reset_o),
    .action_o             (action_o),
    .escalate_o           (escalate_o),
    .rstact_err_o         (rstact_err_o),
    .timeout_o            (timeout_o)
  );

  // {req, chip, action[1:0], escalate, err, timeout}
  typedef struct {
    logic       rv;
    logic [7:0] db;
    logic       gs;
    logic       det;
    logic       ack;
    logic       en;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  function automatic logic [6:0] outs();
    return {periph_reset_req_o, chip_reset_o, action_o, escalate_o, rstact_err_o, timeout_o};
  endfunction

  task automatic idle_inputs();
    rstact_valid_i     = 1'b0;
    rstact_defbyte_i   = 8'h00;
    getstatus_i        = 1'b0;
    detect_i           = 1'b0;
    periph_reset_ack_i = 1'b0;
    enable_i           = 1'b1;
  endtask

  task automatic pulse_detect();
    detect_i = 1'b1;
    cyc();
    detect_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    cyc();
    cyc();
    rst_ni = 1'b1;
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;

    //          rv  db     gs   det  ack  en   req chip act  esc err to
    vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0_0_01_0_0_0};
    vecs[1]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0_0_00_0_0_0};
    vecs[2]  = '{1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0_0_00_0_1_0};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0_0_00_0_0_0};
    vecs[4]  = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0_0_10_0_0_0};
    vecs[5]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0_0_01_0_0_0};
    vecs[6]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0_0_01_0_1_0};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 7'b0_0_01_0_0_0}; // disabled: detect ignored
    vecs[8]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0_0_00_0_0_0};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 7'b0_0_01_1_0_0}; // none -> Holdoff
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 7'b0_0_01_1_0_0}; // ignored in Holdoff
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 7'b0_0_01_0_0_0}; // GETSTATUS clears esc
    vecs[12] = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0_0_10_0_0_0};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0_0_10_0_0_0}; // Holdoff -> Idle
    vecs[14] = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0_0_01_0_0_0};
    vecs[15] = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 1'b1, 7'b1_0_01_1_0_0}; // same-cycle RSTACT+detect
    vecs[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 7'b0_0_01_1_0_0}; // ack -> Holdoff
    vecs[17] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0_0_01_1_0_0}; // Holdoff -> Idle
    vecs[18] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 7'b0_1_01_1_0_0}; // escalated -> ChipRst

    idle_inputs();
    rst_ni = 1'b0;
    cyc();
    chk("reset_outputs", {9'd0, outs()}, {9'd0, 7'b0_0_01_0_0_0});
    rst_ni = 1'b1;
    cyc();

    for (int i = 0; i < 19; i++) begin
      rstact_valid_i     = vecs[i].rv;
      rstact_defbyte_i   = vecs[i].db;
      getstatus_i        = vecs[i].gs;
      detect_i           = vecs[i].det;
      periph_reset_ack_i = vecs[i].ack;
      enable_i           = vecs[i].en;
      cyc();
      chk($sformatf("vec%0d", i), {9'd0, outs()}, {9'd0, vecs[i].exp});
    end
    idle_inputs();

    // Asynchronous reset in the middle of a chip reset.
    cyc();
    chk("chip_before_rst", {15'd0, chip_reset_o}, 16'd1);
    #2 rst_ni = 1'b0;
    #1 chk("async_rst_outputs", {9'd0, outs()}, {9'd0, 7'b0_0_01_0_0_0});
    cyc();
    rst_ni = 1'b1;
    cyc();
    chk("post_rst_outputs", {9'd0, outs()}, {9'd0, 7'b0_0_01_0_0_0});

    // Default periph action with ack after five request cycles.
    pulse_detect();
    chk("periph_req_rise", {14'd0, periph_reset_req_o, escalate_o}, 16'b11);
    repeat (4) cyc();
    chk("periph_req_held", {15'd0, periph_reset_req_o}, 16'd1);
    periph_reset_ack_i = 1'b1;
    cyc();
    periph_reset_ack_i = 1'b0;
    chk("periph_req_fall", {14'd0, periph_reset_req_o, escalate_o}, 16'b01);

    // Holdoff: first cycle and last cycle detects both ignored.
    pulse_detect();
    chk("holdoff_ignore", {9'd0, outs()}, {9'd0, 7'b0_0_01_1_0_0});
    repeat (254) cyc();
    pulse_detect();
    chk("holdoff_last_ignore", {14'd0, periph_reset_req_o, chip_reset_o}, 16'd0);

    // Escalation without GETSTATUS: chip reset for exactly 64 cycles.
    pulse_detect();
    n = 0;
    while (chip_reset_o && n < 200) begin
      n++;
      cyc();
    end
    chk("escalate_chip_len", n[15:0], 16'd64);

    // GETSTATUS between detects returns to a periph request.
    enable_i = 1'b0;
    cyc();
    enable_i = 1'b1;
    getstatus_i = 1'b1;
    cyc();
    getstatus_i = 1'b0;
    chk("getstatus_clear", {15'd0, escalate_o}, 16'd0);
    pulse_detect();
    chk("getstatus_periph", {14'd0, periph_reset_req_o, chip_reset_o}, 16'b10);
    periph_reset_ack_i = 1'b1;
    cyc();
    periph_reset_ack_i = 1'b0;
    enable_i = 1'b0;
    cyc();
    enable_i = 1'b1;

    // RSTACT chip: chip reset for 64 cycles, action reverts to periph.
    rstact_valid_i   = 1'b1;
    rstact_defbyte_i = 8'h02;
    cyc();
    rstact_valid_i   = 1'b0;
    chk("rstact_chip_arm", {13'd0, action_o, escalate_o}, 16'b100);
    pulse_detect();
    chk("rstact_chip_action", {14'd0, action_o}, 16'd1);
    n = 0;
    while (chip_reset_o && n < 200) begin
      n++;
      cyc();
    end
    chk("rstact_chip_len", n[15:0], 16'd64);

    // Ack timeout after 1000 request cycles escalates to chip reset.
    enable_i = 1'b0;
    cyc();
    enable_i = 1'b1;
    getstatus_i = 1'b1;
    cyc();
    getstatus_i = 1'b0;
    pulse_detect();
    n = 0;
    while (periph_reset_req_o && n < 2000) begin
      n++;
      chk("no_early_timeout", {15'd0, timeout_o}, 16'd0);
      cyc();
    end
    chk("timeout_req_len", n[15:0], 16'd1000);
    chk("timeout_pulse", {14'd0, timeout_o, chip_reset_o}, 16'b11);
    cyc();
    chk("timeout_one_cycle", {14'd0, timeout_o, chip_reset_o}, 16'b01);

    // enable_i low in PeriphReq drops the request, keeps action/escalate.
    do_reset();
    pulse_detect();
    cyc();
    chk("en_req_high", {15'd0, periph_reset_req_o}, 16'd1);
    enable_i = 1'b0;
    cyc();
    chk("en_req_drop", {9'd0, outs()}, {9'd0, 7'b0_0_01_1_0_0});
    enable_i = 1'b1;
    pulse_detect();
    chk("en_then_escalate", {14'd0, periph_reset_req_o, chip_reset_o}, 16'b01);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
